// File: rtl/alu_wide_sequencer.sv
// Double-width ADD/SUB/CMP/RSB sequencer built on a single WIDTH-bit adder.
// It runs the low half in one beat and the high half in the next, chaining
// the carry between them, and produces ARM-style NZCV flags.
module alu_wide_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         op,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               n,
  output logic               z,
  output logic               c,
  output logic               v
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned AW = WIDTH + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]    x_q, y_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] lo_sum_q;
  logic             lo_carry_q;
  logic             lo_zero_q;

  logic             is_sub;
  logic [WIDTH-1:0] cur_x, cur_y, y_eff;
  logic             cin;
  logic [AW-1:0]    add_full;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Shared WIDTH-bit adder: selects half by beat, inverts Y for subtracts
  always_comb begin
    is_sub   = (op_q != OP_ADD);
    cur_x    = (state == HI) ? x_q[DW-1:WIDTH] : x_q[WIDTH-1:0];
    cur_y    = (state == HI) ? y_q[DW-1:WIDTH] : y_q[WIDTH-1:0];
    y_eff    = is_sub ? ~cur_y : cur_y;
    cin      = (state == HI) ? lo_carry_q : is_sub;
    add_full = AW'(cur_x) + AW'(y_eff) + AW'(cin);
    sum      = add_full[WIDTH-1:0];
    cout     = add_full[WIDTH];
  end

  // Operand capture, low-beat staging, and result/flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= OP_ADD;
      lo_sum_q   <= '0;
      lo_carry_q <= 1'b0;
      lo_zero_q  <= 1'b0;
      result     <= '0;
      n          <= 1'b0;
      z          <= 1'b0;
      c          <= 1'b0;
      v          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // RSB is computed as X - Y with the operands swapped
            x_q  <= (op == OP_RSB) ? b : a;
            y_q  <= (op == OP_RSB) ? a : b;
            op_q <= op;
          end
        end
        LO: begin
          lo_sum_q   <= sum;
          lo_carry_q <= cout;
          lo_zero_q  <= (sum == '0);
        end
        HI: begin
          n <= sum[WIDTH-1];
          z <= lo_zero_q && (sum == '0);
          c <= cout;
          v <= (cur_x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != cur_x[WIDTH-1]);
          if (op_q != OP_CMP) result <= {sum, lo_sum_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle sequencer that runs double-width (2×WIDTH) ADD/SUB/CMP/RSB operations on a single WIDTH-bit add/invert datapath. It chains the carry across two beats and produces ARM-style NZCV flags. It drives the conditional B-inversion control and carry-in of the shared adder, and sits beside the ALU for 64-bit arithmetic on the 32-bit core. Requests and responses use valid/ready handshakes.

## Interface
- WIDTH, 32, datapath word width; operands and result are 2×WIDTH bits
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (IDLE only)
- op  in  2  00 ADD (A+B), 01 SUB (A−B), 10 CMP (A−B, flags only), 11 RSB (B−A)
- a  in  2×WIDTH  operand A
- b  in  2×WIDTH  operand B
- rsp_valid  out  1  result/flags valid (DONE only)
- rsp_ready  in  1  consumer takes response
- result  out  2×WIDTH  operation result, registered
- n, z, c, v  out  1 each  flags, registered

## Operation
- States: IDLE, LO, HI, DONE. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture a, b, op.
  - For RSB, swap the operands so the sequencer always computes X − Y internally.
  - Go to LO.
- LO:
  - The internal adder computes X[WIDTH-1:0] + (inv ? ~Y : Y)[WIDTH-1:0] + cin.
  - inv=1 and cin=1 for SUB/CMP/RSB. inv=0 and cin=0 for ADD.
  - Register the low sum, the carry-out, and the low-zero bit. Go to HI.
- HI:
  - Same inversion. cin = the registered low carry.
  - Compute the high sum.
  - n = sum[2W-1].
  - z = low-zero AND (high sum == 0).
  - c = high carry-out. For subtract ops c=1 means no borrow.
  - v = (sign X == sign of effective Y) AND (sign sum != sign X).
  - Update result with the full sum, except for CMP, where result keeps its previous value.
  - Flags are always updated. Go to DONE.
- DONE:
  - rsp_valid=1 and req_ready=0; req_valid is ignored.
  - Go to IDLE on the edge where rsp_ready=1.
  - result and flags hold until the next completed operation.
- Arithmetic: modulo 2^(2W), with no saturation. Inputs change freely outside IDLE without effect, because operands are latched.
- Reset (reset=0 on a rising edge), in any state:
  - Next state IDLE.
  - result=0, n=z=c=v=0, rsp_valid=0, req_ready=1 after release.
  - Any in-flight operation is discarded and produces no response.

## Timing
- Request accepted at edge E0 (req_valid & req_ready).
- LO at E1, HI at E2. rsp_valid=1 is visible after E2, i.e. 3 cycles after acceptance.
- Response consumed at edge E3 when rsp_ready=1; req_ready=1 in the following cycle.
- Minimum request-to-request spacing is 4 cycles; no overlap.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- rsp_ready held low keeps DONE, and result/flags stay stable indefinitely.
- rsp_ready high before DONE has no effect.

## Test plan
- ADD a=0x00000000_FFFFFFFF, b=0x1 → result=0x00000001_00000000, NZCV=0000, rsp_valid 3 cycles after accept (checks carry chaining).
- SUB a=5, b=7 → result=0xFFFFFFFF_FFFFFFFE, N=1 Z=0 C=0 V=0.
- CMP a=0x80000000_00000000, b=1, issued after the SUB above → N=0 Z=0 C=1 V=1. result stays 0xFFFFFFFF_FFFFFFFE.
- RSB a=3, b=3 → result=0, N=0 Z=1 C=1 V=0.
- Backpressure:
  - Stimulus: ADD 1+2 with rsp_ready=0 for 5 cycles, and req_valid=1 with different operands throughout.
  - Response: rsp_valid stays 1, result=3 is stable, req_ready=0.
  - After rsp_ready=1, there is one cycle in IDLE, then the new request is accepted.
- Reset mid-operation: assert reset=0 for one edge while in HI → next cycle state IDLE, result=0, NZCV=0000, rsp_valid=0. No response appears afterwards; the next request completes normally.
